// File: rtl/rom_loader_if.sv
// Byte-stream receive handshake and instruction-memory write bus for rom_loader.
interface rom_loader_if #(
    parameter int unsigned ADDR_W = 15
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;

    // Stream source and memory sink side
    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_data
    );

    // Loader side
    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_data
    );
endinterface

// File: rtl/rom_loader.sv
// Boot ROM loader: receives a length-prefixed, checksummed image as a byte
// stream, writes it word by word into instruction memory and releases the CPU
// from reset only after a verified image has been stored.
module rom_loader #(
    parameter int unsigned ADDR_W = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    rom_loader_if.slave   bus,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          error
);
    // One extra index bit so the count never wraps on a full-size image
    localparam int unsigned IDX_W     = ADDR_W + 1;
    localparam int unsigned MAX_WORDS = 1 << ADDR_W;

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        CSUM,
        DONE,
        ERROR
    } state_t;

    state_t           state;
    logic [7:0]       len_hi;
    logic [7:0]       hi_byte;
    logic [7:0]       csum;
    logic [15:0]      len;
    logic [IDX_W-1:0] idx;

    logic             accept;
    logic [15:0]      len_in;
    logic             len_bad;
    logic             last_word;

    // Handshake and image-length decode
    assign accept    = bus.rx_valid && bus.rx_ready;
    assign len_in    = {len_hi, bus.rx_data};
    assign len_bad   = (len_in == 16'd0) || (32'(len_in) > MAX_WORDS);
    assign last_word = ((32'(idx) + 32'd1) == 32'(len));

    // Load sequencer; rx_ready is updated together with every state change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            bus.rx_ready <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_data <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_reset    <= 1'b1;
            len_hi       <= '0;
            hi_byte      <= '0;
            csum         <= '0;
            len          <= '0;
            idx          <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state        <= LEN_HI;
                        bus.rx_ready <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        cpu_reset    <= 1'b1;
                        idx          <= '0;
                        csum         <= '0;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len_hi <= bus.rx_data;
                        state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        if (len_bad) begin
                            state        <= ERROR;
                            bus.rx_ready <= 1'b0;
                            busy         <= 1'b0;
                            error        <= 1'b1;
                            cpu_reset    <= 1'b1;
                        end else begin
                            len   <= len_in;
                            state <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (accept) begin
                        hi_byte <= bus.rx_data;
                        csum    <= csum ^ bus.rx_data;
                        state   <= DATA_LO;
                    end
                end
                DATA_LO: begin
                    if (accept) begin
                        csum         <= csum ^ bus.rx_data;
                        bus.mem_we   <= 1'b1;
                        bus.mem_addr <= idx[ADDR_W-1:0];
                        bus.mem_data <= {hi_byte, bus.rx_data};
                        bus.rx_ready <= 1'b0;
                        state        <= WRITE;
                    end
                end
                WRITE: begin
                    idx          <= idx + IDX_W'(1);
                    bus.rx_ready <= 1'b1;
                    state        <= last_word ? CSUM : DATA_HI;
                end
                CSUM: begin
                    if (accept) begin
                        bus.rx_ready <= 1'b0;
                        busy         <= 1'b0;
                        if (csum == bus.rx_data) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state     <= ERROR;
                            error     <= 1'b1;
                            cpu_reset <= 1'b1;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.rx_ready <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rom_loader.sv
// Randomized bench for rom_loader against a stream-parsing reference model.
module tb_rom_loader;
    localparam int unsigned ADDR_W = 15;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic cpu_reset;
    logic busy;
    logic done;
    logic error;

    always #5 clk = ~clk;

    rom_loader_if #(.ADDR_W(ADDR_W)) bus ();

    rom_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Observed writes {addr, data} and per-cycle protocol checks
    logic [31:0] wr_q[$];
    logic        prev_we = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            prev_we = 1'b0;
        end else begin
            check("done_error_excl", 32'(done & error), 32'd0);
            if (bus.mem_we) begin
                check("we_one_cycle", 32'(prev_we), 32'd0);
                check("ready_low_in_write", 32'(bus.rx_ready), 32'd0);
                wr_q.push_back({16'(bus.mem_addr), bus.mem_data});
            end
            prev_we = bus.mem_we;
        end
    end

    // Reference model: parse the stream as the image format describes it
    logic [31:0] exp_q[$];
    logic        exp_done;
    logic        exp_err;
    int          exp_n;

    task automatic model(input bq_t s);
        int n;
        logic [7:0] x;
        exp_q.delete();
        n = (int'(s[0]) << 8) + int'(s[1]);
        x = 8'h00;
        if (n == 0 || n > (1 << ADDR_W)) begin
            exp_n    = 0;
            exp_done = 1'b0;
            exp_err  = 1'b1;
        end else begin
            exp_n = n;
            for (int k = 0; k < n; k++) begin
                exp_q.push_back({16'(k), s[2+2*k], s[3+2*k]});
                x = x ^ s[2+2*k] ^ s[3+2*k];
            end
            exp_done = (s[2+2*n] == x);
            exp_err  = !exp_done;
        end
    endtask

    // Drive one load; optionally pulse start at a byte index or stop after some writes
    task automatic run_load(input bq_t s, input int valid_pct, input int start_at, input int abort_after);
        int  i;
        int  cyc;
        int  writes_seen;
        bit  xfer;
        bit  pulsed;
        bit  aborted;
        model(s);
        wr_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_cpu_reset", 32'(cpu_reset), 32'd1);
        check("start_done_clr", 32'(done), 32'd0);
        check("start_err_clr", 32'(error), 32'd0);
        i = 0; cyc = 0; writes_seen = 0; pulsed = 1'b0; aborted = 1'b0;
        while (i < s.size()) begin
            if (cyc > 5000) begin
                check("byte_timeout", 32'(i), 32'(s.size()));
                break;
            end
            bus.rx_valid = ($urandom_range(99) < valid_pct);
            bus.rx_data  = s[i];
            if (i == start_at && !pulsed) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            xfer = bus.rx_valid && bus.rx_ready;
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (bus.mem_we) writes_seen++;
            if (xfer) begin
                if (i >= 2 && i < 2 + 2*exp_n && (i % 2) == 1)
                    check("write_latency", 32'(bus.mem_we), 32'd1);
                i++;
            end
            if (abort_after > 0 && writes_seen >= abort_after) begin
                aborted = 1'b1;
                break;
            end
        end
        bus.rx_valid = 1'b0;
        if (!aborted) begin
            check("write_count", 32'(wr_q.size()), 32'(exp_q.size()));
            for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++)
                check($sformatf("write_%0d", k), wr_q[k], exp_q[k]);
            check("end_done", 32'(done), 32'(exp_done));
            check("end_error", 32'(error), 32'(exp_err));
            check("end_busy", 32'(busy), 32'd0);
            check("end_cpu_reset", 32'(cpu_reset), 32'(!exp_done));
            check("end_rx_ready", 32'(bus.rx_ready), 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
        check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, "_mem_data"}, 32'(bus.mem_data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    endtask

    initial begin
        bq_t good;
        bq_t bad_csum;
        bq_t s;
        int  n;
        logic [7:0] x;

        reset        = 1'b1;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        good     = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        bad_csum = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};

        #12;
        check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Nominal image, then checksum mismatch (restart from DONE)
        run_load(good, 100, -1, 0);
        run_load(bad_csum, 100, -1, 0);

        // Illegal lengths: zero and one past the address space
        s = {8'h00, 8'h00};
        run_load(s, 100, -1, 0);
        s = {8'h80, 8'h01};
        run_load(s, 100, -1, 0);

        // Recover from ERROR, then gappy rx_valid
        run_load(good, 40, -1, 0);

        // start pulsed while waiting for the first data byte is ignored
        run_load(good, 100, 2, 0);

        // Asynchronous reset between word 0 and word 1
        run_load(good, 100, -1, 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("no_write_after_reset", 32'(wr_q.size()), 32'd1);
        check("idle_after_reset", 32'(busy), 32'd0);
        run_load(good, 100, -1, 0);

        // Random images with random gaps and occasional checksum corruption
        for (int t = 0; t < 8; t++) begin
            s.delete();
            n = $urandom_range(1, 8);
            s.push_back(8'(n >> 8));
            s.push_back(8'(n));
            x = 8'h00;
            for (int k = 0; k < 2*n; k++) begin
                s.push_back(8'($urandom));
                x = x ^ s[s.size()-1];
            end
            if ($urandom_range(99) < 30)
                x = x ^ 8'($urandom_range(1, 255));
            s.push_back(x);
            run_load(s, $urandom_range(30, 100), -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, instruction-memory address width; max word count 2^ADDR_W.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-005 SHALL have port rx_data  input  8  incoming byte from serial receiver.
REQ-006 SHALL have port rx_valid  input  1  rx_data valid.
REQ-007 SHALL have port rx_ready  output  1  loader accepts byte this cycle.
REQ-008 SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-009 SHALL have port mem_addr  output  ADDR_W  write address.
REQ-010 SHALL have port mem_data  output  16  write data.
REQ-011 SHALL have port cpu_reset  output  1  holds CPU in reset while no valid image is loaded.
REQ-012 SHALL have ports busy, done, error  output  1 each  status flags.

Function
REQ-013 Byte transfer SHALL occur only on a posedge where rx_valid and rx_ready are both 1; rx_data held while rx_valid=1 and rx_ready=0 SHALL NOT be consumed.
REQ-014 States SHALL be IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CSUM, DONE, ERROR.
REQ-015 rx_ready SHALL be 1 exactly in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM; 0 in all other states.
REQ-016 start in IDLE, DONE or ERROR SHALL go to LEN_HI, clear done/error, zero word index and checksum, set busy=1 and cpu_reset=1 next cycle; start in any other state SHALL be ignored.
REQ-017 Stream format: length N big-endian (2 bytes), then N words big-endian (HI then LO), then 1 checksum byte.
REQ-018 On LEN_LO accept, N=0 or N>2^ADDR_W SHALL go to ERROR; otherwise DATA_HI.
REQ-019 Checksum SHALL be 8-bit XOR of all data bytes only (length bytes excluded).
REQ-020 On DATA_LO accept the FSM SHALL enter WRITE; in WRITE, mem_we=1 for exactly one cycle with mem_addr=word index and mem_data={HI,LO}.
REQ-021 After WRITE the index SHALL increment; if index+1==N go to CSUM, else DATA_HI; index SHALL NOT wrap (bounded by REQ-018).
REQ-022 mem_addr and mem_data SHALL hold last written values outside WRITE; mem_we=0 outside WRITE.
REQ-023 On CSUM accept: match -> DONE (done=1, busy=0, cpu_reset=0); mismatch -> ERROR (error=1, busy=0, cpu_reset=1).
REQ-024 done and error SHALL never be 1 simultaneously; busy=1 in all states except IDLE, DONE, ERROR.
REQ-025 Write latency SHALL be 1 cycle from DATA_LO byte acceptance to mem_we assertion.

Reset
REQ-026 reset=1 SHALL immediately force IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_data=0, busy=0, done=0, error=0, cpu_reset=1, independent of clk.
REQ-027 reset mid-load SHALL abort without further mem_we; already-written words are not restored; a new start is required.

Verification
REQ-028 start, bytes 00 02 12 34 AB CD 40 (rx_valid always 1) -> writes 0x1234@0, 0xABCD@1, each 1-cycle mem_we; then done=1, cpu_reset=0, busy=0.
REQ-029 Same stream with checksum 41 -> both writes occur, then error=1, done=0, cpu_reset=1.
REQ-030 start, bytes 00 00 -> ERROR after second byte, no mem_we ever; length 80 01 with ADDR_W=15 -> ERROR.
REQ-031 Valid load with rx_valid toggled randomly -> identical writes and result to REQ-028; no byte consumed while rx_ready=0 during WRITE.
REQ-032 reset asserted between words 0 and 1 of REQ-028 -> outputs at reset values asynchronously; no further writes; new start then full stream -> done=1.
REQ-033 start pulsed while in DATA_HI -> ignored; load completes normally; start from DONE -> new load begins, done clears next cycle.
